// File: rtl/tape_ram_arbiter.sv
// tape_ram_arbiter: grants the single RAM I/O slot to one of the download
// writer (dl), tape reader (tp) or auxiliary reader (aux), one byte per slot.
// Ports: clk, reset (sync, active-high), iocycle (RAM I/O slot),
//   dl_req/dl_addr/dl_data/dl_ack, tp_req/tp_addr/tp_ack,
//   aux_req/aux_addr/aux_ack, rdata (last read byte),
//   ram_rd/ram_we/ram_a/ram_dout/ram_din (SDRAM I/O port).
module tape_ram_arbiter #(
  parameter int ADDR_WIDTH = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iocycle,
  input  logic                  dl_req,
  input  logic [ADDR_WIDTH-1:0] dl_addr,
  input  logic [7:0]            dl_data,
  output logic                  dl_ack,
  input  logic                  tp_req,
  input  logic [ADDR_WIDTH-1:0] tp_addr,
  output logic                  tp_ack,
  input  logic                  aux_req,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  output logic                  aux_ack,
  output logic [7:0]            rdata,
  output logic                  ram_rd,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] W_DL  = 2'd0;
  localparam logic [1:0] W_TP  = 2'd1;
  localparam logic [1:0] W_AUX = 2'd2;

  logic [1:0]            state;
  logic [1:0]            win;
  logic [1:0]            pick;
  // last_rr high: aux was served last, so tp wins the next tie
  logic                  last_rr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            data_q;
  logic                  any_req;
  logic                  slot_on;

  assign any_req = dl_req | tp_req | aux_req;

  always_comb begin
    pick = W_AUX;
    if (dl_req)
      pick = W_DL;
    else if (tp_req && (!aux_req || last_rr))
      pick = W_TP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      win     <= W_DL;
      last_rr <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      rdata   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          // arbitrate only in the low phase so a grant
          // always covers a whole slot
          if (!iocycle && any_req) begin
            state <= S_ARMED;
            win   <= pick;
            unique case (pick)
              W_DL: begin
                addr_q <= dl_addr;
                data_q <= dl_data;
              end
              W_TP: begin
                addr_q  <= tp_addr;
                last_rr <= 1'b0;
              end
              default: begin
                addr_q  <= aux_addr;
                last_rr <= 1'b1;
              end
            endcase
          end
        end
        S_ARMED: begin
          if (iocycle)
            state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!iocycle) begin
            if (win != W_DL)
              rdata <= ram_din;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // strobes track iocycle for the whole high phase of the granted slot
  assign slot_on = iocycle &&
                   ((state == S_ARMED) || (state == S_ACTIVE));

  assign ram_rd   = slot_on && (win != W_DL);
  assign ram_we   = slot_on && (win == W_DL);
  assign ram_a    = addr_q;
  assign ram_dout = data_q;

  assign dl_ack  = (state == S_DONE) && (win == W_DL);
  assign tp_ack  = (state == S_DONE) && (win == W_TP);
  assign aux_ack = (state == S_DONE) && (win == W_AUX);

endmodule
